hazard_fwd_ctrl: RTL

Parametrised hazard controller for the pipelined core: combines N-source operand forwarding selection with load-use stall detection and a multi-cycle stall sequencer. It sits beside the ID/EX boundary. It drives the EX-stage operand multiplexers, the PC and IF/ID write enables, and the ID/EX bubble insertion. It also keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_fwd_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_fwd_ctrl
// Hazard controller placed beside the ID/EX boundary of the pipelined core.
//   * Per-source operand forwarding select for the EX-stage operand muxes
//     (combinational, EX/MEM has priority over MEM/WB, loads in EX/MEM are
//     never forwarded from EX/MEM, register 0 never matches).
//   * Load-use hazard detection with a LOAD_STALL-cycle stall sequencer that
//     freezes PC and IF/ID and injects bubbles into ID/EX.
//   * Saturating performance counter of stalled cycles.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   id_rs, id_uses    IF/ID source addresses / per-source "operand read" flags
//   ex_rs             ID/EX source addresses (same packing as id_rs)
//   ex_rd, ex_regwrite, ex_memread     ID/EX destination info
//   mem_rd, mem_regwrite, mem_memread  EX/MEM destination info
//   wb_rd, wb_regwrite                 MEM/WB destination info
//   stall_clr         clears stall_cycles (priority over increment)
//   fwd_sel           per-source select [2i+1:2i]: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   pc_write_en, ifid_write_en, idex_bubble   stall controls
//   hazard_busy       sequencer is in its STALL state
//   stall_cycles      saturating count of cycles with pc_write_en=0
// -----------------------------------------------------------------------------
module hazard_fwd_ctrl #(
    parameter int REG_W      = 5,
    parameter int NUM_SRC    = 2,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_SRC*REG_W-1:0]   id_rs,
    input  logic [NUM_SRC-1:0]         id_uses,
    input  logic [NUM_SRC*REG_W-1:0]   ex_rs,
    input  logic [REG_W-1:0]           ex_rd,
    input  logic                       ex_regwrite,
    input  logic                       ex_memread,
    input  logic [REG_W-1:0]           mem_rd,
    input  logic                       mem_regwrite,
    input  logic                       mem_memread,
    input  logic [REG_W-1:0]           wb_rd,
    input  logic                       wb_regwrite,
    input  logic                       stall_clr,
    output logic [2*NUM_SRC-1:0]       fwd_sel,
    output logic                       pc_write_en,
    output logic                       ifid_write_en,
    output logic                       idex_bubble,
    output logic                       hazard_busy,
    output logic [CNT_W-1:0]           stall_cycles
);

    localparam int REM_W = $clog2(LOAD_STALL) + 1;
    // A single-cycle stall never needs the STALL state.
    localparam bit MULTI_STALL = (LOAD_STALL > 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               use_match_s;
    logic               hz_s;
    logic               stall_s;

    // Forwarding select per EX-stage source; forced to regfile while in reset.
    always_comb begin
        fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!rst_n) begin
                fwd_sel[2*i +: 2] = 2'b00;
            end else if (mem_regwrite && (mem_rd != '0) && !mem_memread &&
                         (mem_rd == ex_rs[i*REG_W +: REG_W])) begin
                fwd_sel[2*i +: 2] = 2'b10;
            end else if (wb_regwrite && (wb_rd != '0) &&
                         (wb_rd == ex_rs[i*REG_W +: REG_W])) begin
                fwd_sel[2*i +: 2] = 2'b01;
            end else begin
                fwd_sel[2*i +: 2] = 2'b00;
            end
        end
    end

    // Load-use detection: any read operand of the IF/ID instruction needs the load result.
    always_comb begin
        use_match_s = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_uses[i] && (id_rs[i*REG_W +: REG_W] == ex_rd)) begin
                use_match_s = 1'b1;
            end else begin
                use_match_s = use_match_s;
            end
        end
        hz_s = ex_memread && ex_regwrite && (ex_rd != '0) && use_match_s;
    end

    // Stall request: immediate on a hazard in IDLE, unconditional in STALL.
    always_comb begin
        stall_s = 1'b0;
        if (!rst_n) begin
            stall_s = 1'b0;
        end else begin
            case (state_q)
                IDLE:    stall_s = hz_s;
                STALL:   stall_s = 1'b1;
                default: stall_s = 1'b0;
            endcase
        end
    end

    // Sequencer next state; the IDLE hazard cycle counts as the first stall cycle.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (hz_s && MULTI_STALL) begin
                    state_d = STALL;
                    rem_d   = REM_W'(LOAD_STALL - 1);
                end else begin
                    state_d = IDLE;
                    rem_d   = '0;
                end
            end
            STALL: begin
                // rem==1 marks the final stall cycle; hz is ignored here.
                if (rem_q <= REM_W'(1)) begin
                    state_d = IDLE;
                    rem_d   = '0;
                end else begin
                    state_d = STALL;
                    rem_d   = rem_q - REM_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                rem_d   = '0;
            end
        endcase
    end

    // Saturating stall counter; clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (stall_clr) begin
            cnt_d = '0;
        end else if (stall_s && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State, remaining-count and performance-counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc_write_en   = !stall_s;
    assign ifid_write_en = !stall_s;
    assign idex_bubble   = stall_s;
    assign hazard_busy   = rst_n && (state_q == STALL);
    assign stall_cycles  = cnt_q;

endmodule
